// File: rtl/sd_pkg.sv
// Shared SD SPI-mode definitions: command opcodes, tokens, writer state encoding.
package sd_pkg;

  localparam logic [7:0] CMD0         = 8'h40;
  localparam logic [7:0] CMD8         = 8'h48;
  localparam logic [7:0] CMD24        = 8'h58;
  localparam logic [7:0] CMD55        = 8'h77;
  localparam logic [7:0] ACMD41       = 8'h69;
  localparam logic [7:0] START_TOKEN  = 8'hFE;
  localparam logic [4:0] DRESP_ACCEPT = 5'b00101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_CMD_ACK,
    S_GAP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_DRESP,
    S_BUSY,
    S_TAIL
  } wr_state_t;

  // 48-bit SPI command frame with a dummy CRC byte.
  function automatic logic [47:0] cmd_frame(input logic [7:0] op, input logic [31:0] arg);
    return {op, arg, 8'hFF};
  endfunction

endpackage

// File: rtl/sd_resp_rx.sv
// SD response receiver: waits for a start bit (0) on registered miso, then
// captures len bits MSB first (start bit included) and pulses resp_vld.
module sd_resp_rx (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic [3:0] len,
  input  logic       miso_r,
  output logic [7:0] resp,
  output logic       resp_vld
);

  logic       active;
  logic [3:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      resp     <= '0;
      resp_vld <= 1'b0;
    end else begin
      resp_vld <= 1'b0;
      if (!en) begin
        active <= 1'b0;
        cnt    <= '0;
      end else if (active) begin
        resp <= {resp[6:0], miso_r};
        if (cnt == len - 4'd1) begin
          active   <= 1'b0;
          cnt      <= '0;
          resp_vld <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else if (!miso_r) begin
        active <= 1'b1;
        resp   <= '0;
        cnt    <= 4'd1;
      end
    end
  end

endmodule

// File: rtl/sd_write.sv
// SPI-mode single-block writer (CMD24): command, R1, start token, data block,
// dummy CRC, data response and busy wait. Optional timeouts: SD_WR_TIMEOUT_EN.
module sd_write
  import sd_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned GAP_BITS    = 8,
  parameter logic [15:0] TIMEOUT_MAX = 16'd4095
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        miso,
  output logic        cs_n,
  output logic        mosi,
  output logic        wr_data_req,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err
);

  localparam logic [12:0] DATA_LAST = 13'(BLOCK_BYTES * 8 - 1);
  localparam logic [12:0] GAP_LAST  = 13'(GAP_BITS - 1);
  localparam logic [9:0]  LAST_BYTE = 10'(BLOCK_BYTES - 1);

  wr_state_t   state, state_nxt;
  logic [12:0] bit_cnt;
  logic [47:0] shreg;
  logic [31:0] addr_q;
  logic        miso_r;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        rx_en;
  logic [3:0]  rx_len;
  logic        timeout;
  logic        cnt_hold;

  sd_resp_rx u_resp_rx (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (rx_en),
    .len      (rx_len),
    .miso_r   (miso_r),
    .resp     (resp),
    .resp_vld (resp_vld)
  );

`ifdef SD_WR_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        waiting;

  assign waiting = (state == S_CMD_ACK) || (state == S_DRESP) || (state == S_BUSY);
  assign timeout = waiting && (to_cnt == TIMEOUT_MAX);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      to_cnt <= '0;
      wr_err <= 1'b0;
    end else begin
      to_cnt <= (!waiting || state_nxt != state) ? '0 : to_cnt + 16'd1;
      wr_err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign wr_err  = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_en     = (state == S_CMD_ACK) || (state == S_DRESP);
    rx_len    = (state == S_DRESP) ? 4'd5 : 4'd8;
    cnt_hold  = (state == S_IDLE) || (state == S_CMD_ACK) ||
                (state == S_DRESP) || (state == S_BUSY);
    unique case (state)
      S_IDLE:     if (wr_en && init_end) state_nxt = S_SEND_CMD;
      S_SEND_CMD: if (bit_cnt == 13'd47) state_nxt = S_CMD_ACK;
      S_CMD_ACK: begin
        if (timeout)       state_nxt = S_IDLE;
        else if (resp_vld) state_nxt = (resp == 8'h00) ? S_GAP : S_SEND_CMD;
      end
      S_GAP:      if (bit_cnt == GAP_LAST) state_nxt = S_TOKEN;
      S_TOKEN:    if (bit_cnt == 13'd7) state_nxt = S_DATA;
      S_DATA:     if (bit_cnt == DATA_LAST) state_nxt = S_CRC;
      S_CRC:      if (bit_cnt == 13'd15) state_nxt = S_DRESP;
      S_DRESP: begin
        if (timeout)       state_nxt = S_IDLE;
        else if (resp_vld) state_nxt = (resp[4:0] == DRESP_ACCEPT) ? S_BUSY : S_IDLE;
      end
      S_BUSY: begin
        if (timeout)     state_nxt = S_IDLE;
        else if (miso_r) state_nxt = S_TAIL;
      end
      S_TAIL:     if (bit_cnt == GAP_LAST) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // mosi is the shift register MSB; every shift back-fills 1s so idle phases
  // (CMD_ACK, GAP, CRC, DRESP, BUSY, TAIL) drive mosi=1 without extra muxing.
  assign mosi = shreg[47];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt     <= '0;
      shreg       <= '1;
      addr_q      <= '0;
      miso_r      <= 1'b1;
      cs_n        <= 1'b1;
      wr_busy     <= 1'b0;
      wr_done     <= 1'b0;
      wr_data_req <= 1'b0;
    end else begin
      miso_r  <= miso;
      bit_cnt <= (cnt_hold || state_nxt != state) ? '0 : bit_cnt + 13'd1;
      cs_n    <= (state_nxt == S_IDLE);
      wr_busy <= (state_nxt != S_IDLE);
      wr_done <= (state == S_TAIL) && (bit_cnt == GAP_LAST);
      // Request lands on bit 6 so the byte is present for the bit-7 load.
      wr_data_req <= ((state == S_TOKEN) && (bit_cnt == 13'd5)) ||
                     ((state == S_DATA) && (bit_cnt[2:0] == 3'd5) &&
                      (bit_cnt[12:3] != LAST_BYTE));
      if (state == S_IDLE && state_nxt == S_SEND_CMD) addr_q <= wr_addr;

      if (state_nxt == S_SEND_CMD && state != S_SEND_CMD)
        shreg <= cmd_frame(CMD24, (state == S_IDLE) ? wr_addr : addr_q);
      else if (state == S_GAP && state_nxt == S_TOKEN)
        shreg <= {START_TOKEN, 40'hFF_FFFF_FFFF};
      else if (((state == S_TOKEN) || (state == S_DATA && bit_cnt[12:3] != LAST_BYTE)) &&
               (bit_cnt[2:0] == 3'd7))
        shreg <= {wr_data, 40'hFF_FFFF_FFFF};
      else
        shreg <= {shreg[46:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_sd_write.sv
// Randomised scoreboard bench for sd_write: a card model decodes mosi into bytes
// and response events, which are compared against expectations queued at stimulus.
module tb_sd_write;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        miso = 1'b1;
  logic        cs_n, mosi, wr_data_req, wr_busy, wr_done, wr_err;

  always #5 sys_clk = ~sys_clk;

  sd_write dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .init_end   (init_end),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .miso       (miso),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .wr_data_req(wr_data_req),
    .wr_busy    (wr_busy),
    .wr_done    (wr_done),
    .wr_err     (wr_err)
  );

  localparam int K_BYTE = 0, K_DONE = 1, K_ERR = 2;
  localparam int C_WCMD = 0, C_CMD = 1, C_R1 = 2, C_WTOK = 3, C_DATA = 4, C_DRESP = 5;

  typedef struct {int kind; int val;} exp_t;
  exp_t        exp_q[$];
  logic [7:0]  fifo_q[$];
  logic [7:0]  r1_q[$];
  int          n_checks = 0, n_pass = 0, req_cnt = 0;
  bit          feed_pending = 0, mute = 0;
  logic [4:0]  dresp_val = 5'b00101;
  int          busy_len = 20;
  int          cph = C_WCMD, ccnt = 0;
  logic [47:0] csh = '0;
  logic [7:0]  win = '1, cur_r1 = '0, dtok;

  function automatic void check(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void observe(int kind, int val);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_unexpected: got kind %0d val %0h, required nothing pending", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", kind, e.kind);
      if (e.kind == K_BYTE && kind == K_BYTE) check("sb_byte", val, e.val);
    end
  endfunction

  function automatic void push_byte(int b);
    exp_q.push_back('{K_BYTE, b});
  endfunction

  // Card model and output monitor, sampled mid-bit.
  always @(negedge sys_clk) begin
    if (!sys_rst_n || cs_n) begin
      cph = C_WCMD; ccnt = 0; miso = 1'b1;
    end else begin
      case (cph)
        C_WCMD: begin
          miso = 1'b1;
          if (!mosi) begin csh = '0; ccnt = 1; cph = C_CMD; end
        end
        C_CMD: begin
          csh = {csh[46:0], mosi}; ccnt++;
          if (ccnt == 48) begin
            for (int i = 5; i >= 0; i--) observe(K_BYTE, int'(csh[i*8 +: 8]));
            cur_r1 = (r1_q.size() != 0) ? r1_q.pop_front() : 8'h00;
            ccnt = 0; cph = C_R1;
          end
        end
        C_R1: begin
          if (!mute && ccnt >= 2 && ccnt < 10) miso = cur_r1[9 - ccnt];
          else miso = 1'b1;
          ccnt++;
          if (ccnt == 11 && !mute) begin
            win = '1;
            cph = (cur_r1 == 8'h00) ? C_WTOK : C_WCMD;
          end
        end
        C_WTOK: begin
          miso = 1'b1;
          win = {win[6:0], mosi};
          if (!mosi) begin observe(K_BYTE, int'(win)); ccnt = 0; cph = C_DATA; end
        end
        C_DATA: begin
          csh = {csh[46:0], mosi}; ccnt++;
          if (ccnt % 8 == 0) observe(K_BYTE, int'(csh[7:0]));
          if (ccnt == 514 * 8) begin ccnt = 0; cph = C_DRESP; end
        end
        default: begin
          dtok = {3'b111, dresp_val};
          if (ccnt >= 1 && ccnt <= 8) miso = dtok[8 - ccnt];
          else if (ccnt >= 9 && ccnt < 9 + busy_len) miso = 1'b0;
          else miso = 1'b1;
          ccnt++;
        end
      endcase
    end
    if (wr_done) begin
      observe(K_DONE, 0);
      check("done_busy_low", int'(wr_busy), 0);
      check("done_cs_high", int'(cs_n), 1);
    end
    if (wr_err) observe(K_ERR, 0);
    if (wr_data_req) begin req_cnt++; feed_pending = 1; end
  end

  // Upstream FIFO: byte appears the cycle after the request.
  always @(posedge sys_clk) begin
    if (feed_pending) begin
      feed_pending = 0;
      #1;
      if (fifo_q.size() != 0) wr_data = fifo_q.pop_front();
      else begin
        n_checks++;
        $display("FAIL fifo_underflow: got request with empty fifo, required none");
      end
    end
  end

  task automatic wait_idle();
    int waited = 0;
    while (wr_busy && waited < 20000) begin @(negedge sys_clk); waited++; end
    check("busy_release_in_time", int'(waited < 20000), 1);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic run_write(input logic [31:0] addr, input int n_bad, input logic [4:0] dr,
                           input int busy, input bit ramp, input bit poke, input bit abort);
    logic [7:0] b;
    int         waited;
    r1_q.delete();
    for (int a = 0; a <= n_bad; a++) begin
      r1_q.push_back((a == n_bad) ? 8'h00 : 8'($urandom_range(1, 127)));
      push_byte(8'h58);
      for (int i = 3; i >= 0; i--) push_byte(int'(addr[i*8 +: 8]));
      push_byte(8'hFF);
    end
    push_byte(8'hFE);
    for (int k = 0; k < 512; k++) begin
      b = ramp ? 8'(k) : 8'($urandom);
      fifo_q.push_back(b);
      push_byte(int'(b));
    end
    push_byte(8'hFF); push_byte(8'hFF);
    if (dr == 5'b00101) exp_q.push_back('{K_DONE, 0});
    dresp_val = dr; busy_len = busy; req_cnt = 0;

    @(negedge sys_clk); init_end = 1; wr_en = 1; wr_addr = addr;
    @(negedge sys_clk); wr_en = 0; wr_addr = $urandom;
    check("busy_on_accept", int'(wr_busy), 1);

    if (abort) begin
      waited = 0;
      while (req_cnt < 20 && waited < 5000) begin @(negedge sys_clk); waited++; end
      check("abort_reached_data", int'(req_cnt >= 20), 1);
      #2 sys_rst_n = 0; feed_pending = 0;
      #1;
      check("abort_cs_n", int'(cs_n), 1);
      check("abort_mosi", int'(mosi), 1);
      check("abort_req", int'(wr_data_req), 0);
      check("abort_busy", int'(wr_busy), 0);
      check("abort_done", int'(wr_done), 0);
      check("abort_err", int'(wr_err), 0);
      exp_q.delete(); fifo_q.delete();
      @(negedge sys_clk); sys_rst_n = 1;
      repeat (2) @(negedge sys_clk);
      return;
    end

    if (poke) begin
      repeat (200) @(negedge sys_clk);
      wr_en = 1; wr_addr = ~addr;
      @(negedge sys_clk); wr_en = 0; init_end = 0;
      repeat (300) @(negedge sys_clk);
      init_end = 1;
    end

    wait_idle();
    check("sb_drained", exp_q.size(), 0);
    check("req_per_block", req_cnt, 512);
    check("fifo_consumed", fifo_q.size(), 0);
    check("cs_n_idle", int'(cs_n), 1);
    exp_q.delete(); fifo_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cs_low, busy_hi;
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", int'(cs_n), 1);
    check("rst_mosi", int'(mosi), 1);
    check("rst_req", int'(wr_data_req), 0);
    check("rst_busy", int'(wr_busy), 0);
    check("rst_done", int'(wr_done), 0);
    check("rst_err", int'(wr_err), 0);
    sys_rst_n = 1;
    repeat (3) @(negedge sys_clk);

    run_write(32'h0000_0010, 0, 5'b00101, 20, 1'b0, 1'b0, 1'b0);
    run_write($urandom, 0, 5'b00101, 3, 1'b1, 1'b0, 1'b0);

    init_end = 0; cs_low = 0; busy_hi = 0;
    @(negedge sys_clk); wr_en = 1; wr_addr = $urandom;
    @(negedge sys_clk); wr_en = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (!cs_n) cs_low++;
      if (wr_busy) busy_hi++;
    end
    check("no_init_cs_activity", cs_low, 0);
    check("no_init_busy", busy_hi, 0);

    run_write($urandom, 1, 5'b00101, 10, 1'b0, 1'b0, 1'b0);
    run_write($urandom, 0, 5'b01011, 5, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++)
      run_write($urandom, $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? 5'b01101 : 5'b00101,
                $urandom_range(2, 40), 1'b0, 1'b1, 1'b0);
    run_write($urandom, 0, 5'b00101, 10, 1'b0, 1'b0, 1'b1);
    run_write($urandom, 0, 5'b00101, 7, 1'b1, 1'b0, 1'b0);

`ifdef SD_WR_TIMEOUT_EN
    begin
      logic [31:0] ta;
      ta = $urandom;
      mute = 1; r1_q.delete();
      push_byte(8'h58);
      for (int i = 3; i >= 0; i--) push_byte(int'(ta[i*8 +: 8]));
      push_byte(8'hFF);
      exp_q.push_back('{K_ERR, 0});
      @(negedge sys_clk); wr_en = 1; wr_addr = ta;
      @(negedge sys_clk); wr_en = 0;
      wait_idle();
      check("timeout_sb_drained", exp_q.size(), 0);
      check("timeout_cs_n", int'(cs_n), 1);
      exp_q.delete();
      mute = 0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
